ht_serial_rx: RTL
=================

// Module: ht_serial_rx
// PURPOSE
//  Receiving end of the HT 3-wire serial link (HT_SCLK / HT_SLOAD / HT_SDATA) used by the
//  sugar-detector front end. Oversamples the three wires in the clk_50m domain and deserializes
//  16-bit MSB-first frames framed by HT_SLOAD low. Presents each word with a one-cycle valid
//  strobe. Flags malformed frames and stalled links. Used for loopback self-test and for
//  HT-style peripherals that talk back.
// PARAMETERS
//  DATA_W       16    bits per frame
//  SYNC_STAGES  2     flip-flop synchronizer depth on each input wire (>=2)
//  TIMEOUT_CYC  1023  clk_50m cycles with no SCLK rising edge inside a frame before abort
// PORTS
//  clk_50m     in   1       system clock, 50 MHz; only clock in the block
//  rst         in   1       reset, synchronous, active-high
//  HT_SCLK     in   1       serial clock, asynchronous to clk_50m, <= 5 MHz
//  HT_SLOAD    in   1       frame enable, active-low
//  HT_SDATA    in   1       serial data; changes on SCLK falling edge, MSB first
//  Data_Recv   out  DATA_W  last good word; held until next good frame
//  data_valid  out  1       1-cycle pulse when Data_Recv updates
//  frame_err   out  1       1-cycle pulse: frame closed with bit count != DATA_W
//  timeout_err out  1       1-cycle pulse: frame aborted by SCLK inactivity
//  busy        out  1       high while state != IDLE
// BEHAVIOUR
//  Reset: Data_Recv=0, data_valid=0, frame_err=0, timeout_err=0, busy=0.
//   Shift reg, bit counter, timeout counter=0. State=IDLE. Synchronizers load 1 (idle-high lines).
//  Sync: each wire passes SYNC_STAGES FFs. One extra FF gives sclk_rise / sload_fall / sload_rise
//   pulses. All logic below uses synchronized values only.
//  FSM states IDLE, SHIFT, WAIT_HI.
//   IDLE: on sload_fall -> SHIFT; clear bit counter and timeout counter.
//   SHIFT: on sclk_rise with SLOAD low:
//    - shift_reg <= {shift_reg[DATA_W-2:0], sdata}; bitcnt++; timeout counter cleared.
//    - bitcnt saturates at DATA_W+1 (counter width clog2(DATA_W+2)).
//    - Extra bits are still shifted but mark the frame bad.
//   SHIFT: on sload_rise:
//    - bitcnt==DATA_W: next cycle Data_Recv<=shift_reg, data_valid=1.
//    - otherwise: frame_err=1, Data_Recv unchanged.
//    - Then -> IDLE.
//   SHIFT: timeout counter reaches TIMEOUT_CYC-1 with no sclk_rise:
//    - timeout_err=1 -> WAIT_HI. No data_valid.
//   WAIT_HI: ignore SCLK; on sload_rise -> IDLE (no further pulses).
//  Simultaneous sclk_rise and sload_rise in one cycle: the bit is shifted first and counted
//   toward the length check.
//  sclk_rise while SLOAD high or in IDLE: ignored.
//  Latency: data_valid rises SYNC_STAGES+2 clk_50m cycles after the HT_SLOAD pin rising edge.
//  Back-to-back frames: sload_fall on the cycle right after returning to IDLE is accepted.
//   Minimum SLOAD-high gap is 2 synchronized cycles.
//  rst mid-frame: immediate return to reset values. The partial frame is discarded silently.
//   The next frame is only accepted after a fresh SLOAD falling edge.
//  At most one of data_valid/frame_err/timeout_err is high in any cycle.
// STRUCTURE
//  Shared package/include ht_serial_defs.vh:
//   - HT_DATA_W=16
//   - HT_SCLK_DIV=50 (clk_50m cycles per SCLK, 25 high)
//   - FSM state encodings
//  The transmitter uses the same defines.
//  One sub-module: ht_sync_edge (SYNC_STAGES synchronizer plus rise/fall pulse outputs).
//   Instantiated 3x, for SCLK, SLOAD and SDATA (SDATA uses the level only).
//  Top holds the FSM, shift register, bit counter and timeout counter.
// TESTING
//  Loopback with HT_Serial, Data_Send=16'hA5C3, start released:
//   -> one data_valid, Data_Recv=16'hA5C3, no errors; repeats every frame.
//  Bench driver sends 16'h8001, then 16'h7FFE back-to-back at 1 MHz SCLK:
//   -> two data_valid pulses, in that order, values exact.
//  Frame of 15 bits, then frame of 17 bits:
//   -> frame_err pulse each; Data_Recv keeps previous 16'h7FFE.
//  SLOAD low, 5 bits sent, SCLK stopped for 1100 cycles, then SLOAD high:
//   -> timeout_err at cycle 1023 after last edge; no frame_err; back to IDLE.
//  rst asserted for 1 cycle after 8 bits of a frame:
//   -> all outputs 0 next cycle; remaining 8 bits with SLOAD still low are ignored.
//   Next full frame 16'h1234 is received correctly.
//  SCLK toggling with SLOAD high for 40 edges -> no pulses, busy stays 0.

Source files
------------

// File: rtl/ht_serial_rx_pkg.sv
// Shared definitions for the HT 3-wire serial link (receiver and transmitter).
package ht_serial_rx_pkg;

  localparam int unsigned HT_DATA_W   = 16;
  localparam int unsigned HT_SCLK_DIV = 50;  // clk_50m cycles per SCLK period, 25 high

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_WAIT_HI = 2'd2
  } ht_state_t;

endpackage

// File: rtl/ht_serial_rx_if.sv
// HT serial link wires plus the receiver's word/status outputs.
interface ht_serial_rx_if
  import ht_serial_rx_pkg::*;
#(
  parameter int unsigned DATA_W = HT_DATA_W
);

  logic              HT_SCLK;
  logic              HT_SLOAD;
  logic              HT_SDATA;
  logic [DATA_W-1:0] Data_Recv;
  logic              data_valid;
  logic              frame_err;
  logic              timeout_err;
  logic              busy;

  modport master (
    output HT_SCLK, HT_SLOAD, HT_SDATA,
    input  Data_Recv, data_valid, frame_err, timeout_err, busy
  );

  modport slave (
    input  HT_SCLK, HT_SLOAD, HT_SDATA,
    output Data_Recv, data_valid, frame_err, timeout_err, busy
  );

endinterface

// File: rtl/ht_serial_rx_sync_edge.sv
// Multi-stage synchronizer for one idle-high wire, with registered rise/fall pulses.
// The level output is taken from the edge-detect FF so it is aligned with the pulses.
module ht_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   rise_q;
  logic                   fall_q;

  // Synchronizer chain, delayed copy and edge pulses; reset to the idle-high level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      last_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      last_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~last_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & last_q;
    end
  end

  assign level = last_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ht_serial_rx.sv
// HT serial receiver: deserializes 16-bit MSB-first frames framed by HT_SLOAD low,
// flags wrong-length frames and SCLK stalls inside a frame.
module ht_serial_rx
  import ht_serial_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = HT_DATA_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input logic          clk_50m,
  input logic          rst,
  ht_serial_rx_if.slave ht
);

  localparam int unsigned BCW    = $clog2(DATA_W + 2);
  localparam int unsigned TCW    = $clog2(TIMEOUT_CYC);
  localparam int unsigned SETTLE = SYNC_STAGES + 1;
  localparam int unsigned SCW    = $clog2(SETTLE + 1);

  localparam logic [BCW-1:0] BIT_FULL = BCW'(DATA_W);
  localparam logic [BCW-1:0] BIT_SAT  = BCW'(DATA_W + 1);
  localparam logic [TCW-1:0] TCNT_END = TCW'(TIMEOUT_CYC - 1);
  localparam logic [SCW-1:0] SET_END  = SCW'(SETTLE);

  logic sclk_rise, sload_lvl, sload_rise, sload_fall, sdata_lvl;
  logic sclk_lvl_unused, sclk_fall_unused, sdata_rise_unused, sdata_fall_unused;

  ht_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_nx;
  logic [BCW-1:0]    bitcnt_q, bitcnt_nx;
  logic [TCW-1:0]    tcnt_q;
  logic [SCW-1:0]    settle_q;
  logic              armed_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q, ferr_q, terr_q;
  logic              shift_en, good_close, bad_close, tmo_hit, busy_c;

  ht_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk_50m), .rst(rst), .din(ht.HT_SCLK),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  ht_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sload (
    .clk(clk_50m), .rst(rst), .din(ht.HT_SLOAD),
    .level(sload_lvl), .rise(sload_rise), .fall(sload_fall)
  );

  ht_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk(clk_50m), .rst(rst), .din(ht.HT_SDATA),
    .level(sdata_lvl), .rise(sdata_rise_unused), .fall(sdata_fall_unused)
  );

  // Arming: after reset the synchronizers reload 1, so a still-low SLOAD would fake a
  // falling edge; only accept frames once the settled SLOAD level has been seen high.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      if (settle_q != SET_END) settle_q <= settle_q + 1'b1;
      if (settle_q == SET_END && sload_lvl) armed_q <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk_50m) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (sload_fall && armed_q) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (sload_rise)   state_d = ST_IDLE;
        else if (tmo_hit) state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: if (sload_rise) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: shift/count decode and frame-close classification.
  // A bit arriving in the same cycle as the SLOAD rise is folded in before the length check.
  always_comb begin
    busy_c     = (state_q != ST_IDLE);
    shift_en   = (state_q == ST_SHIFT) && sclk_rise && (!sload_lvl || sload_rise);
    shift_nx   = shift_en ? {shift_q[DATA_W-2:0], sdata_lvl} : shift_q;
    bitcnt_nx  = (shift_en && bitcnt_q != BIT_SAT) ? bitcnt_q + 1'b1 : bitcnt_q;
    good_close = (state_q == ST_SHIFT) && sload_rise && (bitcnt_nx == BIT_FULL);
    bad_close  = (state_q == ST_SHIFT) && sload_rise && (bitcnt_nx != BIT_FULL);
    tmo_hit    = (state_q == ST_SHIFT) && !sload_rise && !sclk_rise && (tcnt_q == TCNT_END);
  end

  // Datapath: shift register, bit counter, inactivity counter and registered result pulses
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      shift_q  <= '0;
      bitcnt_q <= '0;
      tcnt_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      valid_q <= good_close;
      ferr_q  <= bad_close;
      terr_q  <= tmo_hit;
      if (good_close) data_q <= shift_nx;
      if (state_q == ST_IDLE) begin
        bitcnt_q <= '0;
        tcnt_q   <= '0;
      end else if (state_q == ST_SHIFT) begin
        shift_q  <= shift_nx;
        bitcnt_q <= bitcnt_nx;
        if (sclk_rise)               tcnt_q <= '0;
        else if (tcnt_q != TCNT_END) tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end

  assign ht.Data_Recv   = data_q;
  assign ht.data_valid  = valid_q;
  assign ht.frame_err   = ferr_q;
  assign ht.timeout_err = terr_q;
  assign ht.busy        = busy_c;

endmodule
